logic_result_stage: RTL and testbench

Downstream pipeline stage that consumes the 32-bit logic-unit result and its 2-bit op code and buffers them in a 2-entry skid FIFO with a valid/ready handshake. At capture it derives zero, negative and parity flags, and it counts accepted results. It decouples the combinational logic unit from a stalling consumer (writeback / register file) without dropping or duplicating results.

---
 rtl/logic_result_stage.sv | 113 +++++++++++
 tb/tb_logic_result_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_result_stage.sv
// logic_result_stage: 2-entry skid FIFO behind the logic unit.
// Captures each accepted result with its op code and derived flags
// (zero, negative, parity), and counts accepted results.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        upstream handshake (push on both high)
//   in_result, in_op         logic-unit result and its op code
//   out_valid/out_ready      downstream handshake (pop on both high)
//   out_result, out_op       head entry payload
//   out_zero/neg/parity      head entry flags, captured at push time
//   op_count                 accepted pushes since reset, wrapping
module logic_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_parity,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned DEPTH = 2;

  // State encoding equals the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic             head;
  logic             tail;
  logic [WIDTH-1:0] mem_result [DEPTH];
  logic [1:0]       mem_op     [DEPTH];
  logic [DEPTH-1:0] mem_zero;
  logic [DEPTH-1:0] mem_neg;
  logic [DEPTH-1:0] mem_parity;

  logic push;
  logic pop;
  logic in_zero;
  logic in_neg;
  logic in_parity;

  // Ready depends only on registered state, so out_ready never reaches in_ready.
  assign in_ready  = (state != FULL) && !rst;
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flags derived once, at capture.
  assign in_zero   = (in_result == '0);
  assign in_neg    = in_result[WIDTH-1];
  assign in_parity = ^in_result;

  // Head entry drives the outputs straight from storage registers.
  assign out_result = mem_result[head];
  assign out_op     = mem_op[head];
  assign out_zero   = mem_zero[head];
  assign out_neg    = mem_neg[head];
  assign out_parity = mem_parity[head];

  // Occupancy FSM, pointers, storage and accept counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      head       <= 1'b0;
      tail       <= 1'b0;
      op_count   <= '0;
      mem_zero   <= '0;
      mem_neg    <= '0;
      mem_parity <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_result[i] <= '0;
        mem_op[i]     <= '0;
      end
    end else begin
      if (push) begin
        mem_result[tail] <= in_result;
        mem_op[tail]     <= in_op;
        mem_zero[tail]   <= in_zero;
        mem_neg[tail]    <= in_neg;
        mem_parity[tail] <= in_parity;
        tail             <= ~tail;
        op_count         <= op_count + CNT_W'(1);
      end
      if (pop) begin
        head <= ~head;
      end
      case (state)
        EMPTY: if (push) state <= ONE;
        ONE: begin
          if (push && !pop)      state <= FULL;
          else if (pop && !push) state <= EMPTY;
        end
        FULL: if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_result_stage.sv
// Directed self-checking bench for logic_result_stage.
module tb_logic_result_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_op;
  logic        out_zero;
  logic        out_neg;
  logic        out_parity;
  logic [15:0] op_count;

  // Narrow-counter instance for the wrap check.
  logic        in_valid4;
  logic        in_ready4;
  logic        out_valid4;
  logic        out_ready4;
  logic [31:0] out_result4;
  logic [1:0]  out_op4;
  logic        out_zero4;
  logic        out_neg4;
  logic        out_parity4;
  logic [3:0]  op_count4;

  int checks;
  int errors;

  logic_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity),
    .op_count(op_count)
  );

  logic_result_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_result(32'h0000_0003), .in_op(2'b01),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_result(out_result4), .out_op(out_op4),
    .out_zero(out_zero4), .out_neg(out_neg4), .out_parity(out_parity4),
    .op_count(op_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] data, input logic [1:0] op);
    check("push_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_result = data;
    in_op     = op;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_result  = '0;
    in_op      = '0;
    out_ready  = 1'b0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    step();
    step();

    // Reset state.
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_flags", {29'd0, out_zero, out_neg, out_parity}, 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    step();

    // Single zero push.
    push_one(32'h0000_0000, 2'b00);
    check("zero_valid", 32'(out_valid), 32'd1);
    check("zero_flags", {29'd0, out_zero, out_neg, out_parity}, 32'b100);
    check("zero_count", 32'(op_count), 32'd1);
    pop_one();
    check("zero_popped", 32'(out_valid), 32'd0);

    // Flag derivation.
    push_one(32'h8000_0001, 2'b11);
    check("neg_result", out_result, 32'h8000_0001);
    check("neg_op", 32'(out_op), 32'd3);
    check("neg_flags", {29'd0, out_zero, out_neg, out_parity}, 32'b010);
    pop_one();
    push_one(32'h0000_0007, 2'b10);
    check("par_flags", {29'd0, out_zero, out_neg, out_parity}, 32'b001);
    check("par_op", 32'(out_op), 32'd2);
    pop_one();
    check("flags_count", 32'(op_count), 32'd3);

    // Backpressure.
    push_one(32'hAAAA_AAAA, 2'b00);
    push_one(32'h5555_5555, 2'b01);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    in_valid  = 1'b1;
    in_result = 32'h1234_5678;
    in_op     = 2'b10;
    step();
    check("bp_hold_result", out_result, 32'hAAAA_AAAA);
    check("bp_no_accept", 32'(op_count), 32'd5);
    step();
    check("bp_stable", out_result, 32'hAAAA_AAAA);
    out_ready = 1'b1;
    step();
    check("bp_second", out_result, 32'h5555_5555);
    check("bp_second_op", 32'(out_op), 32'd1);
    check("bp_count_mid", 32'(op_count), 32'd5);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_third", out_result, 32'h1234_5678);
    check("bp_third_count", 32'(op_count), 32'd6);
    step();
    out_ready = 1'b0;
    check("bp_drained", 32'(out_valid), 32'd0);

    // Streaming from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid  = 1'b1;
      in_result = 32'h100 + 32'(i);
      in_op     = 2'(i);
      step();
      check("stream_data", {out_valid, out_result[30:0]}, {1'b1, 31'h100 + 31'(i)});
    end
    in_valid = 1'b0;
    check("stream_count", 32'(op_count), 32'd100);
    step();
    check("stream_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset while full.
    push_one(32'hDEAD_BEEF, 2'b11);
    push_one(32'h0BAD_F00D, 2'b00);
    check("mid_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_count", 32'(op_count), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("mid_rel_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    step();
    check("mid_no_stale", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      in_valid4 = 1'b1;
      step();
    end
    in_valid4 = 1'b0;
    check("wrap_count", 32'(op_count4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
